regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-read-port register file with an integrated pending-write scoreboard, serving as the operand store between decode and writeback in the pipelined core. It holds NREG registers of XLEN bits and optionally hardwires register 0 to zero. Decode marks destination registers pending at issue, and writeback clears them. Each read port reports whether its operand is currently valid.

## Interface
- XLEN, 32, register width in bits
- NREG, 32, number of registers; power of two, ≥ 2
- AW, $clog2(NREG), address width; derived, never overridden
- NRP, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and ignores issue marks

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- rd_addr  in  NRP*AW  read addresses; port p is at bits [p*AW +: AW]
- rd_data  out  NRP*XLEN  read data; port p is at bits [p*XLEN +: XLEN]
- rd_ready  out  NRP  port p operand is valid (not pending, or bypassed)
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback register
- wr_data  in  XLEN  writeback data
- iss_en  in  1  mark a destination register pending
- iss_addr  in  AW  register to mark
- flush  in  1  clear all pending bits (pipeline squash)
- pend_cnt  out  AW+1  number of registers currently pending

## Operation
- Storage is NREG×XLEN flops plus an NREG-bit pending vector. pend_cnt is a registered counter.
- Reset (rst_n=0 at a posedge) has the following effects:
  - All registers are set to 0, all pending bits to 0, and pend_cnt to 0.
  - All rd_ready bits read 1 and all rd_data read 0.
  - wr_en, iss_en and flush are ignored during that cycle.
- Write: when wr_en=1 at a posedge, reg[wr_addr] ← wr_data and pending[wr_addr] ← 0. If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Issue: when iss_en=1 at a posedge, pending[iss_addr] ← 1. If ZERO_REG=1 and iss_addr=0, the issue is ignored. Re-issuing a register that is already pending leaves it pending and does not change the count.
- Issue and write to the same register in the same cycle:
  - The data is written.
  - Pending ends at 1, because the newer producer wins.
- Flush: all pending bits ← 0 and pend_cnt ← 0.
  - Flush has priority over an issue in the same cycle; that issue is dropped.
  - A write in the same cycle still updates the register data.
- pend_cnt tracks popcount(pending) exactly. Each cycle it changes by +1, −1 or 0 according to the effective set and clear events. It never exceeds NREG−ZERO_REG and never underflows.
- Reads are combinational from storage:
  - rd_data[p] = reg[rd_addr[p]]
  - rd_ready[p] = !pending[rd_addr[p]]
  - If ZERO_REG=1 and rd_addr[p]=0, the port reads data 0 with rd_ready=1.
- All read ports are independent; any number of them may address the same register.

## Timing
- Read latency is 0 cycles (combinational).
- Write-to-read latency is 1 cycle without bypass, and 0 cycles with REGFILE_BYPASS_EN.
- Issue-to-not-ready latency is 1 cycle: rd_ready drops after the issuing posedge.
- Write-to-ready latency is 1 cycle without bypass, and 0 cycles with bypass.
- pend_cnt updates at the same posedge as the pending vector.
- There is no handshake back-pressure. Every accepted strobe takes effect in exactly one cycle.

## Configuration
- REGFILE_BYPASS_EN defined: write-to-read forwarding is enabled.
  - Condition: wr_en=1, rd_addr[p]=wr_addr, and the address is not the zero register.
  - Effect: rd_data[p]=wr_data and rd_ready[p]=1 in that same cycle, before the posedge.
  - Forwarding applies to every read port.
- REGFILE_BYPASS_EN undefined: there is no forwarding path. Readers see the old data and rd_ready=0 (if pending) until the cycle after the write.
- Sequential state and pend_cnt behave identically in both builds.

## Test plan
- Reset: drive rst_n=0 for 1 cycle with wr_en=1, wr_addr=5, wr_data=0xDEADBEEF. Afterwards, reg5 reads 0, all rd_ready=1 and pend_cnt=0.
- Issue/writeback: issue x7, and check rd_ready=0 and pend_cnt=1 on the next cycle. Then write x7=0x1234 and check per build:
  - without bypass: rd_ready=0 in the write cycle, then 1 with data 0x1234 on the next cycle
  - with bypass: rd_ready=1 and data 0x1234 in the write cycle itself
  - pend_cnt returns to 0 in both builds.
- Zero register: write x0=0xFFFFFFFF and issue x0. x0 reads 0 with rd_ready=1, and pend_cnt stays 0.
- Same-cycle collision: x3 is pending; in one cycle, issue x3 and write x3=0xAA. Afterwards x3 reads 0xAA, rd_ready=0, and pend_cnt is unchanged.
- Flush priority: issue x1, x2 and x4 (pend_cnt=3). Then drive flush together with an issue of x9 and a write x9=0x55. Afterwards pend_cnt=0, x9 is ready with 0x55, and x1/x2/x4 are ready with their old data.
- Multi-port: with NRP=4, all ports address x10 while x10=0x99 is written. Under bypass all four ports return 0x99 in the same cycle; without bypass they return 0x99 on the next cycle.

Source files
------------

// File: rtl/regfile_sb.sv
// Multi-read-port register file with a pending-write scoreboard for decode/writeback.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data and readiness to the read ports.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int NRP      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRP*AW-1:0]   rd_addr,
  output logic [NRP*XLEN-1:0] rd_data,
  output logic [NRP-1:0]      rd_ready,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                flush,
  output logic [AW:0]         pend_cnt
);

  // rd_ready is a level status, not a handshake: 1 means rd_data of that port holds
  // the committed (or forwarded) operand. Strobes have no back-pressure and always land.

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;
  logic [AW:0]     cnt_q;
  logic [AW:0]     cnt_d;
  logic            wr_eff;
  logic            iss_eff;
  logic            cnt_inc;
  logic            cnt_dec;

  assign wr_eff  = rst_n && wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
  assign iss_eff = rst_n && iss_en && !flush && !((ZERO_REG != 0) && (iss_addr == '0));

  // A same-register issue+write leaves the register pending, so it is never a clear.
  always_comb begin
    pending_d = pending_q;
    cnt_d     = cnt_q;
    cnt_inc   = 1'b0;
    cnt_dec   = 1'b0;
    if (flush) begin
      pending_d = '0;
      cnt_d     = '0;
    end else begin
      if (wr_eff)  pending_d[wr_addr]  = 1'b0;
      if (iss_eff) pending_d[iss_addr] = 1'b1;
      cnt_inc = iss_eff && !pending_q[iss_addr];
      cnt_dec = wr_eff && pending_q[wr_addr] && !(iss_eff && (iss_addr == wr_addr));
      cnt_d   = cnt_q + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      if (wr_eff) regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    logic [AW-1:0] ra;
    ra       = '0;
    rd_data  = '0;
    rd_ready = '0;
    for (int p = 0; p < NRP; p++) begin
      ra = rd_addr[p*AW +: AW];
      rd_data[p*XLEN +: XLEN] = regs[ra];
      rd_ready[p]             = !pending_q[ra];
`ifdef REGFILE_BYPASS_EN
      if (wr_eff && (wr_addr == ra)) begin
        rd_data[p*XLEN +: XLEN] = wr_data;
        rd_ready[p]             = 1'b1;
      end
`endif
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rd_data[p*XLEN +: XLEN] = '0;
        rd_ready[p]             = 1'b1;
      end
    end
  end

  assign pend_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: directed scenarios then random traffic against
// an array/popcount model; build with or without REGFILE_BYPASS_EN.
module tb_regfile_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);
  localparam int NRP  = 4;
  localparam int DW   = NRP*XLEN;
  localparam int W    = DW + NRP + AW + 1;

  logic                clk;
  logic                rst_n;
  logic [NRP*AW-1:0]   rd_addr;
  logic [NRP*XLEN-1:0] rd_data;
  logic [NRP-1:0]      rd_ready;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                flush;
  logic [AW:0]         pend_cnt;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_ready(rd_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .pend_cnt(pend_cnt)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: architectural registers and pending flags
  logic [XLEN-1:0] m_reg  [NREG];
  bit              m_pend [NREG];

  logic [W-1:0] exp_q [$];
  string        name_q [$];
  int total = 0;
  int bad   = 0;

  function automatic logic [W-1:0] expect_now();
    logic [DW-1:0]  d;
    logic [NRP-1:0] r;
    int             cnt;
    int             a;
    d = '0;
    r = '0;
    cnt = 0;
    for (int p = 0; p < NRP; p++) begin
      a = int'(rd_addr[p*AW +: AW]);
      if (a == 0) begin
        d[p*XLEN +: XLEN] = '0;
        r[p] = 1'b1;
      end else begin
        d[p*XLEN +: XLEN] = m_reg[a];
        r[p] = !m_pend[a];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (int'(wr_addr) == a)) begin
          d[p*XLEN +: XLEN] = wr_data;
          r[p] = 1'b1;
        end
`endif
      end
    end
    for (int i = 0; i < NREG; i++) cnt += int'(m_pend[i]);
    return {d, r, (AW+1)'(cnt)};
  endfunction

  task automatic model_update();
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        m_reg[i]  = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (wr_en && wr_addr != '0) begin
        m_reg[wr_addr]  = wr_data;
        m_pend[wr_addr] = 1'b0;
      end
      if (flush) begin
        for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
      end else if (iss_en && iss_addr != '0) begin
        m_pend[iss_addr] = 1'b1;
      end
    end
  endtask

  function automatic logic [NRP*AW-1:0] ra4(input int a0, input int a1, input int a2, input int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  // driver: apply one cycle of inputs, queue the expected read-side view, then clock the model
  task automatic drive(input string nm, input int r, input int we, input int wa,
                       input logic [XLEN-1:0] wd, input int ie, input int ia,
                       input int fl, input logic [NRP*AW-1:0] ra, input int chk);
    rst_n    = (r != 0);
    wr_en    = (we != 0);
    wr_addr  = AW'(wa);
    wr_data  = wd;
    iss_en   = (ie != 0);
    iss_addr = AW'(ia);
    flush    = (fl != 0);
    rd_addr  = ra;
    if (chk != 0) begin
      exp_q.push_back(expect_now());
      name_q.push_back(nm);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  // monitor: the read view is always presented, so compare on every negedge with a queued entry
  initial begin
    logic [W-1:0] e;
    string        nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        total++;
        if (rd_data !== e[W-1 -: DW]) begin
          bad++;
          $display("FAIL %s rd_data: got %h want %h", nm, rd_data, e[W-1 -: DW]);
        end
        total++;
        if (rd_ready !== e[AW+1 +: NRP]) begin
          bad++;
          $display("FAIL %s rd_ready: got %b want %b", nm, rd_ready, e[AW+1 +: NRP]);
        end
        total++;
        if (pend_cnt !== e[AW:0]) begin
          bad++;
          $display("FAIL %s pend_cnt: got %0d want %0d", nm, pend_cnt, e[AW:0]);
        end
      end
    end
  end

  initial begin
    int guard;
    int rr, we, wa, ie, ia, fl;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; flush = 1'b0; rd_addr = '0;
    for (int i = 0; i < NREG; i++) begin
      m_reg[i] = '0;
      m_pend[i] = 1'b0;
    end

    // reset with a write pending on the inputs
    drive("reset", 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, ra4(5, 5, 5, 5), 0);
    drive("post_reset", 1, 0, 0, '0, 0, 0, 0, ra4(5, 7, 0, 31), 1);

    // issue then writeback
    drive("issue7", 1, 0, 0, '0, 1, 7, 0, ra4(7, 7, 1, 0), 1);
    drive("pend7", 1, 0, 0, '0, 0, 0, 0, ra4(7, 7, 7, 7), 1);
    drive("wb7", 1, 1, 7, 32'h1234, 0, 0, 0, ra4(7, 7, 7, 7), 1);
    drive("after_wb7", 1, 0, 0, '0, 0, 0, 0, ra4(7, 7, 7, 7), 1);

    // zero register ignores writes and issues
    drive("zero_wr", 1, 1, 0, 32'hFFFFFFFF, 1, 0, 0, ra4(0, 0, 0, 0), 1);
    drive("zero_chk", 1, 0, 0, '0, 0, 0, 0, ra4(0, 0, 0, 0), 1);

    // same-cycle issue + write on an already pending register
    drive("iss3", 1, 0, 0, '0, 1, 3, 0, ra4(3, 3, 3, 3), 1);
    drive("coll3", 1, 1, 3, 32'hAA, 1, 3, 0, ra4(3, 3, 3, 3), 1);
    drive("coll3_chk", 1, 0, 0, '0, 0, 0, 0, ra4(3, 3, 3, 3), 1);
    drive("clr3", 1, 1, 3, 32'hAA, 0, 0, 0, ra4(3, 3, 3, 3), 1);

    // flush beats a same-cycle issue, write still lands
    drive("w1", 1, 1, 1, 32'h11, 0, 0, 0, ra4(1, 2, 4, 9), 1);
    drive("w2", 1, 1, 2, 32'h22, 1, 1, 0, ra4(1, 2, 4, 9), 1);
    drive("w4", 1, 1, 4, 32'h44, 1, 2, 0, ra4(1, 2, 4, 9), 1);
    drive("iss4", 1, 0, 0, '0, 1, 4, 0, ra4(1, 2, 4, 9), 1);
    drive("pend3", 1, 0, 0, '0, 0, 0, 0, ra4(1, 2, 4, 9), 1);
    drive("flush", 1, 1, 9, 32'h55, 1, 9, 1, ra4(9, 1, 2, 4), 1);
    drive("flush_chk", 1, 0, 0, '0, 0, 0, 0, ra4(9, 1, 2, 4), 1);

    // all four ports on the register being written
    drive("mp_wr10", 1, 1, 10, 32'h99, 0, 0, 0, ra4(10, 10, 10, 10), 1);
    drive("mp_chk10", 1, 0, 0, '0, 0, 0, 0, ra4(10, 10, 10, 10), 1);

    // random traffic biased toward a few registers to provoke collisions
    for (int i = 0; i < 500; i++) begin
      rr = ($urandom_range(0, 99) != 0) ? 1 : 0;
      we = ($urandom_range(0, 2) == 0) ? 1 : 0;
      wa = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, NREG-1));
      ie = ($urandom_range(0, 1) != 0) ? 1 : 0;
      ia = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, NREG-1));
      fl = ($urandom_range(0, 39) == 0) ? 1 : 0;
      drive("rand", rr, we, wa, $urandom(), ie, ia, fl,
            ra4(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                (wa), int'($urandom_range(0, NREG-1))), rr);
    end
    drive("final", 1, 0, 0, '0, 0, 0, 0, ra4(1, 2, 3, 4), 1);

    // scoreboard must drain within a bounded number of cycles
    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d queued want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
